// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared 32-bit combinational ALU.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter #(
  parameter int bit_size = 32,
  parameter int NUM_REQ  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [3:0]          req0_op,
  input  logic [bit_size-1:0] req0_src1,
  input  logic [bit_size-1:0] req0_src2,
  input  logic [4:0]          req0_shamt,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [3:0]          req1_op,
  input  logic [bit_size-1:0] req1_src1,
  input  logic [bit_size-1:0] req1_src2,
  input  logic [4:0]          req1_shamt,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [bit_size-1:0] rsp_result,
  output logic                rsp_zero,
  output logic                rsp_id,
  output logic                busy
);

  localparam bit TWO_REQ = (NUM_REQ == 2);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

  function automatic logic [bit_size-1:0] alu_f(
    input logic [3:0]          op,
    input logic [bit_size-1:0] a,
    input logic [bit_size-1:0] b,
    input logic [4:0]          sh
  );
    logic [bit_size-1:0] y;
    case (op)
      4'b0001: y = a + b;
      4'b0010: y = a - b;
      4'b0011: y = a & b;
      4'b0100: y = a | b;
      4'b0101: y = a ^ b;
      4'b0110: y = ~(a | b);
      4'b0111: y = (a < b) ? {{(bit_size-1){1'b0}}, 1'b1} : {bit_size{1'b0}};
      4'b1000: y = b << sh;
      4'b1001: y = b >> sh;
      default: y = {bit_size{1'b0}};
    endcase
    return y;
  endfunction

  state_t              r_state;
  logic                r_grant_id;
  logic [3:0]          r_op;
  logic [bit_size-1:0] r_src1;
  logic [bit_size-1:0] r_src2;
  logic [4:0]          r_shamt;
  logic                r_rsp_valid;
  logic [bit_size-1:0] r_rsp_result;
  logic                r_rsp_zero;
  logic                r_rsp_id;
  logic                r_busy;

  logic                w_idle;
  logic                w_pick1;
  logic                w_accept;
  logic [bit_size-1:0] w_alu_result;

  assign w_alu_result = alu_f(r_op, r_src1, r_src2, r_shamt);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_pick1 = TWO_REQ & req1_valid & ~req0_valid;
`else
  logic r_last_grant;

  // Requester 1 wins when alone, or when both are valid and 0 won last time.
  assign w_pick1 = TWO_REQ & req1_valid & (~req0_valid | ~r_last_grant);

  // Round-robin history, moved only when a request is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_pick1;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end
`endif

  // Ready is gated by rst so nothing is granted while reset is held.
  assign w_idle     = (r_state == S_IDLE) & rst;
  assign req0_ready = w_idle & req0_valid & ~w_pick1;
  assign req1_ready = w_idle & w_pick1;
  assign w_accept   = req0_ready | req1_ready;

  // Main FSM: accept and latch operands, execute one cycle, hold the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_grant_id   <= 1'b0;
      r_op         <= 4'b0000;
      r_src1       <= {bit_size{1'b0}};
      r_src2       <= {bit_size{1'b0}};
      r_shamt      <= 5'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= {bit_size{1'b0}};
      r_rsp_zero   <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_grant_id <= w_pick1;
            r_op       <= w_pick1 ? req1_op    : req0_op;
            r_src1     <= w_pick1 ? req1_src1  : req0_src1;
            r_src2     <= w_pick1 ? req1_src2  : req0_src2;
            r_shamt    <= w_pick1 ? req1_shamt : req0_shamt;
            r_busy     <= 1'b1;
            r_state    <= S_EXEC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          r_rsp_result <= w_alu_result;
          r_rsp_zero   <= (w_alu_result == {bit_size{1'b0}});
          r_rsp_id     <= r_grant_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_RESP;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_id     = r_rsp_id;
  assign busy       = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed corner cases, random traffic.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = 4'd0, req1_op = 4'd0;
  logic [31:0] req0_src1 = 32'd0, req0_src2 = 32'd0, req1_src1 = 32'd0, req1_src2 = 32'd0;
  logic [4:0]  req0_shamt = 5'd0, req1_shamt = 5'd0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_id, busy;

  int checks = 0;
  int errors = 0;
  int last_win = 1;

  alu_arbiter #(.bit_size(32), .NUM_REQ(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_shamt(req1_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU written with plain arithmetic modulo 2^32.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    longint unsigned m = 64'h1_0000_0000;
    longint unsigned ua = a, ub = b;
    case (op)
      4'd1: return 32'((ua + ub) % m);
      4'd2: return 32'((ua + m - ub) % m);
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return ~(a | b);
      4'd7: return (ua < ub) ? 32'd1 : 32'd0;
      4'd8: return 32'((ub * (64'd1 << sh)) % m);
      4'd9: return 32'(ub / (64'd1 << sh));
      default: return 32'd0;
    endcase
  endfunction

  function automatic int pick(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return 1 - last_win;
`endif
    end
    return v1 ? 1 : 0;
  endfunction

  // Entered between a negedge and the next posedge with the DUT idle.
  task automatic do_txn(input logic v0, input logic v1,
                        input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] s0,
                        input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] s1,
                        input int bp);
    int w;
    logic [31:0] er;
    req0_valid = v0; req0_op = op0; req0_src1 = a0; req0_src2 = b0; req0_shamt = s0;
    req1_valid = v1; req1_op = op1; req1_src1 = a1; req1_src2 = b1; req1_shamt = s1;
    rsp_ready = 1'b0;
    w  = pick(v0, v1);
    er = (w == 1) ? alu_ref(op1, a1, b1, s1) : alu_ref(op0, a0, b0, s0);
    #1;
    chk("grant_rdy0", req0_ready, (w == 0) ? 1 : 0);
    chk("grant_rdy1", req1_ready, (w == 1) ? 1 : 0);
    last_win = w;
    @(negedge clk);
    if (w == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_no_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_result", rsp_result, er);
    chk("rsp_zero", rsp_zero, (er == 32'd0) ? 1 : 0);
    chk("rsp_id", rsp_id, w);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, er);
      chk("bp_id", rsp_id, w);
      chk("bp_busy", busy, 1);
      chk("bp_no_ready", {req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("done_valid", rsp_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_hold_result", rsp_result, er);
  endtask

  vec_t vt[11];

  initial begin
    vt[0]  = '{4'd1, 32'd3,          32'd5,          5'd0,  32'd8,          1'b0};
    vt[1]  = '{4'd1, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b1};
    vt[2]  = '{4'd7, 32'd2,          32'hFFFF_FFFE,  5'd0,  32'd1,          1'b0};
    vt[3]  = '{4'd4, 32'h0000_00F0,  32'h0000_000F,  5'd0,  32'h0000_00FF,  1'b0};
    vt[4]  = '{4'd2, 32'd7,          32'd7,          5'd0,  32'd0,          1'b1};
    vt[5]  = '{4'd8, 32'd0,          32'd1,          5'd4,  32'd16,         1'b0};
    vt[6]  = '{4'd2, 32'd0,          32'd1,          5'd0,  32'hFFFF_FFFF,  1'b0};
    vt[7]  = '{4'd9, 32'd0,          32'h8000_0000,  5'd31, 32'd1,          1'b0};
    vt[8]  = '{4'd0, 32'h1234_5678,  32'h9ABC_DEF0,  5'd3,  32'd0,          1'b1};
    vt[9]  = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5'd1,  32'd0,          1'b1};
    vt[10] = '{4'd7, 32'hFFFF_FFFE,  32'd2,          5'd0,  32'd0,          1'b1};

    // Reset held with both requesters valid.
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdy", {req0_ready, req1_ready}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", rsp_result, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("first_idle_rdy0", req0_ready, 1);
    chk("first_idle_rdy1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // Vector table; a lone requester always wins, alternating sides.
    for (int i = 0; i < 11; i++) begin
      if (i % 2 == 0)
        do_txn(1'b1, 1'b0, vt[i].op, vt[i].a, vt[i].b, vt[i].sh, 4'd0, 32'd0, 32'd0, 5'd0, 0);
      else
        do_txn(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0, vt[i].op, vt[i].a, vt[i].b, vt[i].sh, 0);
      chk("vec_result", rsp_result, vt[i].res);
      chk("vec_zero", rsp_zero, vt[i].zero);
    end

    // Both valid: round-robin 0,1,0,1 (fixed priority 0,0,0,0).
    last_win = 1;
    rst = 1'b0; @(negedge clk); rst = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b1, 1'b1, 4'd2, 32'd7, 32'd7, 5'd0, 4'd8, 32'd0, 32'd1, 5'd4, 0);
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("rr_id", rsp_id, 0);
      chk("rr_res", rsp_result, 0);
`else
      chk("rr_id", rsp_id, i % 2);
      chk("rr_res", rsp_result, (i % 2 == 1) ? 16 : 0);
`endif
    end

    // Backpressure for five cycles with the other requester waiting.
    do_txn(1'b1, 1'b1, 4'd1, 32'd10, 32'd20, 5'd0, 4'd3, 32'hF0F0, 32'hFF00, 5'd0, 5);
    do_txn(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0, 4'd3, 32'hF0F0, 32'hFF00, 5'd0, 0);
    chk("bp_then_req1", rsp_id, 1);
    chk("bp_then_req1_res", rsp_result, 32'h0000_F000);

    // Reset during EXEC drops the operation.
    req0_valid = 1'b1; req0_op = 4'd1; req0_src1 = 32'd1; req0_src2 = 32'd1;
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    last_win = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("midrst_no_rsp", rsp_valid, 0);
    do_txn(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0, 4'd4, 32'h0000_00F0, 32'h0000_000F, 5'd0, 0);
    chk("midrst_or", rsp_result, 32'h0000_00FF);
    chk("midrst_id", rsp_id, 1);

    // Random traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic v0, v1;
      logic [31:0] a0, a1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      a0 = $urandom;
      a1 = $urandom;
      do_txn(v0, v1,
             4'($urandom_range(0, 15)), a0, ($urandom_range(0, 3) == 0) ? a0 : 32'($urandom), 5'($urandom),
             4'($urandom_range(0, 15)), a1, ($urandom_range(0, 3) == 0) ? a1 : 32'($urandom), 5'($urandom),
             $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
